pulse_sequencer: RTL and testbench

Synchronous controller that sequences the clock-driven pulse datapath: on a start request it latches a configuration and emits a train of `num_pulses` pulses, each `high_len` clock cycles high, separated by `low_len` cycles low. It replaces free-running, delay-based pulse generation with a cycle-exact, restartable and abortable sequence. It sits between the clock generator and any block needing timed strobes, and handshakes with its requester through `start`, `busy` and `done`.

---
 rtl/pulse_sequencer.sv | 124 ++++++++++++
 tb/tb_pulse_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sequencer.sv
// Cycle-exact pulse train controller: start latches config, emits
// num_pulses pulses of high_len/low_len cycles, with abort and done strobe.
module pulse_sequencer #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] high_len,
  input  logic [CW-1:0] low_len,
  input  logic [CW-1:0] num_pulses,
  output logic          pulse,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    FINISH
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] h_m1, h_m1_nx;
  logic [CW-1:0] l_m1, l_m1_nx;
  logic [CW-1:0] rem_nx;
  logic          pulse_nx;
  logic          busy_nx;
  logic          done_nx;

  // Phase counters hold length-1, so a zero length behaves as one cycle
  // and the all-ones length still fits without wrapping.
  function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      h_m1      <= '0;
      l_m1      <= '0;
      remaining <= '0;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      h_m1      <= h_m1_nx;
      l_m1      <= l_m1_nx;
      remaining <= rem_nx;
      pulse     <= pulse_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    h_m1_nx  = h_m1;
    l_m1_nx  = l_m1;
    rem_nx   = remaining;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_pulses != '0) begin
            state_nx = HIGH;
            h_m1_nx  = len_m1(high_len);
            l_m1_nx  = len_m1(low_len);
            cnt_nx   = len_m1(high_len);
            rem_nx   = num_pulses;
          end else begin
            state_nx = FINISH;
            rem_nx   = '0;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_nx = FINISH;
        end else if (cnt == '0) begin
          rem_nx = remaining - 1'b1;
          if (remaining > 1) begin
            state_nx = LOW;
            cnt_nx   = l_m1;
          end else begin
            state_nx = FINISH;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          state_nx = FINISH;
        end else if (cnt == '0) begin
          state_nx = HIGH;
          cnt_nx   = h_m1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      FINISH: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pulse_nx = (state_nx == HIGH);
    busy_nx  = (state_nx == HIGH) || (state_nx == LOW);
    done_nx  = (state_nx == FINISH);
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: hand-computed per-edge tables
// plus a CW=4 instance for the all-ones no-wrap case.
module tb_pulse_sequencer;

  logic       clock;
  logic       reset_n;
  logic       start, abort;
  logic [7:0] high_len, low_len, num_pulses;
  logic       pulse, busy, done;
  logic [7:0] remaining;

  logic       m_start, m_abort;
  logic [3:0] m_high_len, m_low_len, m_num_pulses;
  logic       m_pulse, m_busy, m_done;
  logic [3:0] m_remaining;

  int n_tests = 0;
  int n_fail  = 0;

  pulse_sequencer #(.CW(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
    .pulse      (pulse),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  pulse_sequencer #(.CW(4)) dut_max (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (m_start),
    .abort      (m_abort),
    .high_len   (m_high_len),
    .low_len    (m_low_len),
    .num_pulses (m_num_pulses),
    .pulse      (m_pulse),
    .busy       (m_busy),
    .done       (m_done),
    .remaining  (m_remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic p, input logic b,
                           input logic d, input logic [7:0] r);
    check({tag, ".pulse"}, pulse, p);
    check({tag, ".busy"}, busy, b);
    check({tag, ".done"}, done, d);
    check({tag, ".rem"}, remaining, r);
  endtask

  task automatic cfg(input logic [7:0] h, input logic [7:0] l,
                     input logic [7:0] n);
    high_len   = h;
    low_len    = l;
    num_pulses = n;
  endtask

  // per-edge expectations, bit [N-1-i] is the value after edge i
  logic [8:0] nom_p, nom_b, nom_d;
  int         nom_r[9] = '{2, 2, 1, 1, 1, 1, 1, 0, 0};
  logic [6:0] zf_p, zf_b, zf_d;
  int         zf_r[7] = '{3, 2, 2, 1, 1, 0, 0};
  logic [5:0] ig_p, ig_b, ig_d;
  int         ig_r[6] = '{2, 1, 1, 0, 0, 9};

  int busy_cnt, high_cnt, done_cnt;

  initial begin
    nom_p = 9'b110001100;
    nom_b = 9'b111111100;
    nom_d = 9'b000000010;
    zf_p  = 7'b1010100;
    zf_b  = 7'b1111100;
    zf_d  = 7'b0000010;
    ig_p  = 6'b101001;
    ig_b  = 6'b111001;
    ig_d  = 6'b000100;

    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    cfg(8'd0, 8'd0, 8'd0);
    m_start      = 1'b0;
    m_abort      = 1'b0;
    m_high_len   = 4'd15;
    m_low_len    = 4'd15;
    m_num_pulses = 4'd15;
    #3;
    check_out("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_out("idle", 1'b0, 1'b0, 1'b0, 8'd0);

    // nominal H=2 L=3 n=2
    cfg(8'd2, 8'd3, 8'd2);
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      start = 1'b0;
      check_out($sformatf("nom.e%0d", i), nom_p[8-i], nom_b[8-i],
                nom_d[8-i], nom_r[i][7:0]);
    end

    // zero lengths: behave as 1
    cfg(8'd0, 8'd0, 8'd3);
    start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      start = 1'b0;
      check_out($sformatf("zero.e%0d", i), zf_p[6-i], zf_b[6-i],
                zf_d[6-i], zf_r[i][7:0]);
    end

    // empty sequence
    cfg(8'd5, 8'd5, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_out("empty.e0", 1'b0, 1'b0, 1'b1, 8'd0);
    tick();
    check_out("empty.e1", 1'b0, 1'b0, 1'b0, 8'd0);
    tick();

    // abort in second cycle of first LOW
    cfg(8'd4, 8'd4, 8'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_out("abort.e0", 1'b1, 1'b1, 1'b0, 8'd3);
    for (int i = 1; i < 6; i++) tick();
    check_out("abort.e5", 1'b0, 1'b1, 1'b0, 8'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_out("abort.e6", 1'b0, 1'b0, 1'b1, 8'd2);
    tick();
    check_out("abort.e7", 1'b0, 1'b0, 1'b0, 8'd2);
    abort = 1'b1;
    tick();
    check_out("abort_idle.a", 1'b0, 1'b0, 1'b0, 8'd2);
    tick();
    abort = 1'b0;
    check_out("abort_idle.b", 1'b0, 1'b0, 1'b0, 8'd2);

    // start held, config changed mid-run
    cfg(8'd1, 8'd1, 8'd2);
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) cfg(8'd5, 8'd7, 8'd9);
      check_out($sformatf("ign.e%0d", i), ig_p[5-i], ig_b[5-i],
                ig_d[5-i], ig_r[i][7:0]);
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_out("ign.abort", 1'b0, 1'b0, 1'b1, 8'd9);
    tick();

    // async reset mid-HIGH
    cfg(8'd3, 8'd1, 8'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_out("rst.pre", 1'b1, 1'b1, 1'b0, 8'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("rst.async", 1'b0, 1'b0, 1'b0, 8'd0);
    #2;
    reset_n = 1'b1;
    tick();
    check_out("rst.idle", 1'b0, 1'b0, 1'b0, 8'd0);
    cfg(8'd1, 8'd1, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_out("rst.restart", 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    check_out("rst.fin", 1'b0, 1'b0, 1'b1, 8'd0);

    // all-ones on CW=4: 15*15 + 14*15 busy cycles
    busy_cnt = 0;
    high_cnt = 0;
    done_cnt = 0;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    check("max.rem0", m_remaining, 32'd15);
    for (int i = 0; i < 500; i++) begin
      if (m_busy)  busy_cnt++;
      if (m_pulse) high_cnt++;
      if (m_done)  done_cnt++;
      tick();
    end
    check("max.busy", busy_cnt, 32'd435);
    check("max.high", high_cnt, 32'd225);
    check("max.done", done_cnt, 32'd1);
    check("max.rem_end", m_remaining, 32'd0);
    check("max.idle", m_busy, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
